// File: rtl/mdu_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mdu_sequencer_pkg
//  Description : Shared types and constants for the multiply/divide sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package mdu_sequencer_pkg;

    localparam int MDU_XLEN  = 64;
    localparam int MDU_WLEN  = 32;
    localparam int MDU_CNT_W = $clog2(MDU_XLEN) + 1;

    typedef enum logic [4:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR,  ALU_XOR, ALU_SLL,
        ALU_SRL, ALU_SRA, ALU_SLT, ALU_MUL, ALU_DIV, ALU_REM
    } alufunc_t;

    typedef enum logic [1:0] {
        MDU_IDLE, MDU_MUL, MDU_DIV, MDU_DONE
    } mdu_state_t;

    function automatic logic is_md_func(input logic [4:0] f);
        return (f == ALU_MUL) || (f == ALU_DIV) || (f == ALU_REM);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mdu_div_core.sv
`default_nettype none
// ============================================================================
//  Module      : mdu_div_core
//  Description : Iterative restoring divider datapath, one quotient bit per step.
//  Revision    : 1.0 - initial release
// ============================================================================
module mdu_div_core #(
    parameter int XLEN = 64,
    parameter int WLEN = 32
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            start,
    input  logic            step,
    input  logic            cut,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] q,
    output logic [XLEN-1:0] r
);

    logic [XLEN-1:0] r_rem, r_quo, r_dvs;
    logic [XLEN-1:0] w_rem_src, w_quo_src, w_dvs_src;
    logic [XLEN:0]   w_shift, w_diff;
    logic            w_ge;

    // start performs the first step directly on the incoming operands; word
    // dividends sit in the top half so their bits are consumed first.
    always_comb begin
        w_rem_src = r_rem;
        w_quo_src = r_quo;
        w_dvs_src = r_dvs;
        if (start) begin
            w_rem_src = '0;
            w_quo_src = cut ? {dividend[WLEN-1:0], {(XLEN-WLEN){1'b0}}} : dividend;
            w_dvs_src = divisor;
        end
        w_shift = {w_rem_src, w_quo_src[XLEN-1]};
        w_diff  = w_shift - {1'b0, w_dvs_src};
        // partial remainder stays below 2*divisor, so the top bit is a pure borrow
        w_ge    = ~w_diff[XLEN];
        r       = w_ge ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0];
        q       = {w_quo_src[XLEN-2:0], w_ge};
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rem <= '0;
            r_quo <= '0;
            r_dvs <= '0;
        end else if (start || step) begin
            r_rem <= r;
            r_quo <= q;
            r_dvs <= w_dvs_src;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mdu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : mdu_sequencer
//  Description : Multi-cycle MUL/DIV/REM controller that stalls execute until done.
//  Revision    : 1.0 - initial release
// ============================================================================
module mdu_sequencer
    import mdu_sequencer_pkg::*;
#(
    parameter int XLEN = MDU_XLEN,
    parameter int WLEN = MDU_WLEN
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            valid_i,
    input  logic [4:0]      func_i,
    input  logic            sign_i,
    input  logic            cut_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  logic            advance_i,
    input  logic            flush_i,
    output logic            stall_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

    localparam int              c_cnt_w   = $clog2(XLEN) + 1;
    // the issue cycle performs the first step, so the counter holds the remainder
    localparam logic [c_cnt_w-1:0] c_steps_x = c_cnt_w'(XLEN - 1);
    localparam logic [c_cnt_w-1:0] c_steps_w = c_cnt_w'(WLEN - 1);
    localparam logic [XLEN-1:0] c_min_x   = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] c_min_w   = {{(XLEN-WLEN+1){1'b1}}, {(WLEN-1){1'b0}}};

    function automatic logic [XLEN-1:0] sext_word(input logic [XLEN-1:0] v);
        return {{(XLEN-WLEN){v[WLEN-1]}}, v[WLEN-1:0]};
    endfunction

    function automatic logic [XLEN-1:0] zext_word(input logic [XLEN-1:0] v);
        return {{(XLEN-WLEN){1'b0}}, v[WLEN-1:0]};
    endfunction

    function automatic logic [XLEN-1:0] fit(input logic [XLEN-1:0] v, input logic cut);
        return cut ? sext_word(v) : v;
    endfunction

    mdu_state_t         r_state, w_state_nxt;
    logic [c_cnt_w-1:0] r_cnt;
    logic [XLEN-1:0]    r_acc, r_mcand, r_mplier, r_result;
    logic               r_cut, r_is_rem, r_q_neg, r_r_neg;

    logic            w_is_md, w_is_mul, w_is_rem;
    logic            w_start_mul, w_start_div, w_start_spec, w_mul_step, w_div_step, w_last;
    logic [XLEN-1:0] w_a_ext, w_b_ext, w_a_abs, w_b_abs;
    logic            w_a_neg, w_b_neg, w_b_zero, w_ovf, w_div_special;
    logic [XLEN-1:0] w_special_res;
    logic [XLEN-1:0] w_acc_src, w_mcand_src, w_mplier_src, w_acc_nxt;
    logic [XLEN-1:0] w_q_nxt, w_r_nxt, w_q_mag, w_r_mag, w_q_fix, w_r_fix, w_div_res;

    assign w_is_md  = valid_i & is_md_func(func_i);
    assign w_is_mul = (func_i == ALU_MUL);
    assign w_is_rem = (func_i == ALU_REM);

    // operand view: word ops take the low half, extended per sign_i
    assign w_a_ext  = cut_i ? (sign_i ? sext_word(a_i) : zext_word(a_i)) : a_i;
    assign w_b_ext  = cut_i ? (sign_i ? sext_word(b_i) : zext_word(b_i)) : b_i;
    assign w_a_neg  = sign_i & w_a_ext[XLEN-1];
    assign w_b_neg  = sign_i & w_b_ext[XLEN-1];
    assign w_a_abs  = w_a_neg ? -w_a_ext : w_a_ext;
    assign w_b_abs  = w_b_neg ? -w_b_ext : w_b_ext;

    assign w_b_zero      = (w_b_ext == '0);
    assign w_ovf         = sign_i & (w_a_ext == (cut_i ? c_min_w : c_min_x)) & (&w_b_ext);
    assign w_div_special = w_b_zero | w_ovf;
    assign w_special_res = fit(w_b_zero ? (w_is_rem ? w_a_ext : '1)
                                        : (w_is_rem ? '0 : w_a_ext), cut_i);

    assign w_acc_src    = w_start_mul ? '0      : r_acc;
    assign w_mcand_src  = w_start_mul ? w_a_ext : r_mcand;
    assign w_mplier_src = w_start_mul ? w_b_ext : r_mplier;
    assign w_acc_nxt    = w_acc_src + (w_mplier_src[0] ? w_mcand_src : '0);

    mdu_div_core #(
        .XLEN (XLEN),
        .WLEN (WLEN)
    ) u_div_core (
        .clk      (clk),
        .resetn   (resetn),
        .start    (w_start_div),
        .step     (w_div_step),
        .cut      (cut_i),
        .dividend (w_a_abs),
        .divisor  (w_b_abs),
        .q        (w_q_nxt),
        .r        (w_r_nxt)
    );

    assign w_q_mag   = r_cut ? zext_word(w_q_nxt) : w_q_nxt;
    assign w_r_mag   = r_cut ? zext_word(w_r_nxt) : w_r_nxt;
    assign w_q_fix   = r_q_neg ? -w_q_mag : w_q_mag;
    assign w_r_fix   = r_r_neg ? -w_r_mag : w_r_mag;
    assign w_div_res = fit(r_is_rem ? w_r_fix : w_q_fix, r_cut);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= MDU_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_start_mul  = 1'b0;
        w_start_div  = 1'b0;
        w_start_spec = 1'b0;
        w_mul_step   = 1'b0;
        w_div_step   = 1'b0;
        w_last       = 1'b0;
        if (flush_i) begin
            w_state_nxt = MDU_IDLE;
        end else begin
            case (r_state)
                MDU_IDLE: begin
                    if (w_is_md) begin
                        if (w_is_mul) begin
                            w_start_mul = 1'b1;
                            w_state_nxt = MDU_MUL;
                        end else if (w_div_special) begin
                            w_start_spec = 1'b1;
                            w_state_nxt  = MDU_DONE;
                        end else begin
                            w_start_div = 1'b1;
                            w_state_nxt = MDU_DIV;
                        end
                    end
                end
                MDU_MUL: begin
                    w_mul_step = 1'b1;
                    if (r_cnt == c_cnt_w'(1)) begin
                        w_last      = 1'b1;
                        w_state_nxt = MDU_DONE;
                    end
                end
                MDU_DIV: begin
                    w_div_step = 1'b1;
                    if (r_cnt == c_cnt_w'(1)) begin
                        w_last      = 1'b1;
                        w_state_nxt = MDU_DONE;
                    end
                end
                MDU_DONE: begin
                    if (advance_i) begin
                        w_state_nxt = MDU_IDLE;
                    end
                end
                default: w_state_nxt = MDU_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_result <= '0;
            r_cut    <= 1'b0;
            r_is_rem <= 1'b0;
            r_q_neg  <= 1'b0;
            r_r_neg  <= 1'b0;
        end else begin
            if (w_start_mul || w_start_div) begin
                r_cnt <= cut_i ? c_steps_w : c_steps_x;
                r_cut <= cut_i;
            end else if (w_mul_step || w_div_step) begin
                r_cnt <= r_cnt - c_cnt_w'(1);
            end
            if (w_start_mul || w_mul_step) begin
                r_acc    <= w_acc_nxt;
                r_mcand  <= w_mcand_src << 1;
                r_mplier <= w_mplier_src >> 1;
            end
            if (w_start_div) begin
                r_is_rem <= w_is_rem;
                r_q_neg  <= w_a_neg ^ w_b_neg;
                r_r_neg  <= w_a_neg;
            end
            if (w_start_spec) begin
                r_result <= w_special_res;
            end else if (w_last) begin
                r_result <= (r_state == MDU_MUL) ? fit(w_acc_nxt, r_cut) : w_div_res;
            end
        end
    end

    // reset gating keeps stall low while reset is held, even with a claim pending
    assign stall_o  = resetn & w_is_md & (r_state != MDU_DONE);
    assign done_o   = (r_state == MDU_DONE);
    assign result_o = r_result;

endmodule
`default_nettype wire

// File: tb/tb_mdu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mdu_sequencer
//  Description : Self-checking bench for mdu_sequencer against an arithmetic model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mdu_sequencer;
    import mdu_sequencer_pkg::*;

    logic        clk = 1'b0;
    logic        resetn, valid_i, sign_i, cut_i, advance_i, flush_i;
    logic [4:0]  func_i;
    logic [63:0] a_i, b_i;
    logic        stall_o, done_o;
    logic [63:0] result_o;

    int n_cmp = 0;
    int n_bad = 0;

    mdu_sequencer dut (
        .clk       (clk),
        .resetn    (resetn),
        .valid_i   (valid_i),
        .func_i    (func_i),
        .sign_i    (sign_i),
        .cut_i     (cut_i),
        .a_i       (a_i),
        .b_i       (b_i),
        .advance_i (advance_i),
        .flush_i   (flush_i),
        .stall_o   (stall_o),
        .done_o    (done_o),
        .result_o  (result_o)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] ref_result(input logic [4:0] f, input logic s, input logic c,
                                               input logic [63:0] a, input logic [63:0] b);
        logic [31:0] a32, b32, r32;
        logic [63:0] r64;
        a32 = a[31:0];
        b32 = b[31:0];
        if (c) begin
            if (f == ALU_MUL)                                        r32 = a32 * b32;
            else if (b32 == 32'h0)                                   r32 = (f == ALU_DIV) ? 32'hFFFF_FFFF : a32;
            else if (s && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) r32 = (f == ALU_DIV) ? a32 : 32'h0;
            else if (s && f == ALU_DIV)                              r32 = $signed(a32) / $signed(b32);
            else if (s)                                              r32 = $signed(a32) % $signed(b32);
            else if (f == ALU_DIV)                                   r32 = a32 / b32;
            else                                                     r32 = a32 % b32;
            return {{32{r32[31]}}, r32};
        end
        if (f == ALU_MUL)                                            r64 = a * b;
        else if (b == 64'h0)                                         r64 = (f == ALU_DIV) ? '1 : a;
        else if (s && a == {1'b1, 63'h0} && b == '1)                 r64 = (f == ALU_DIV) ? a : 64'h0;
        else if (s && f == ALU_DIV)                                  r64 = $signed(a) / $signed(b);
        else if (s)                                                  r64 = $signed(a) % $signed(b);
        else if (f == ALU_DIV)                                       r64 = a / b;
        else                                                         r64 = a % b;
        return r64;
    endfunction

    function automatic int ref_latency(input logic [4:0] f, input logic s, input logic c,
                                       input logic [63:0] a, input logic [63:0] b);
        logic special;
        if (f == ALU_MUL) return c ? 32 : 64;
        if (c) special = (b[31:0] == 0) || (s && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF);
        else   special = (b == 0) || (s && a == {1'b1, 63'h0} && b == '1);
        return special ? 1 : (c ? 32 : 64);
    endfunction

    // Issues an op and waits (bounded) for done_o; lat=200 signals a timeout.
    task automatic run_op(input logic [4:0] f, input logic s, input logic c,
                          input logic [63:0] a, input logic [63:0] b, input bit no_wait,
                          output logic [63:0] res, output int lat, output int stalls);
        if (!no_wait) @(negedge clk);
        valid_i = 1'b1; func_i = f; sign_i = s; cut_i = c; a_i = a; b_i = b;
        advance_i = 1'b0; flush_i = 1'b0;
        #1;
        lat = 0;
        stalls = 0;
        while (done_o !== 1'b1 && lat < 200) begin
            if (stall_o === 1'b1) stalls++;
            @(negedge clk);
            #1;
            lat++;
        end
        res = result_o;
    endtask

    task automatic retire();
        advance_i = 1'b1;
        @(negedge clk);
        advance_i = 1'b0;
        valid_i   = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0; valid_i = 1'b0; func_i = ALU_ADD; sign_i = 1'b0; cut_i = 1'b0;
        a_i = '0; b_i = '0; advance_i = 1'b0; flush_i = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        n_cmp++; if (stall_o !== 1'b0) begin n_bad++; $display("FAIL reset_stall got=%b exp=0", stall_o); end
        n_cmp++; if (done_o !== 1'b0) begin n_bad++; $display("FAIL reset_done got=%b exp=0", done_o); end
        n_cmp++; if (result_o !== 64'h0) begin n_bad++; $display("FAIL reset_result got=%h exp=0", result_o); end
        @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic test_mul_basic();
        logic [63:0] res; int lat, st;
        run_op(ALU_MUL, 1'b0, 1'b0, 64'd7, -64'sd3, 1'b0, res, lat, st);
        n_cmp++; if (res !== -64'sd21) begin n_bad++; $display("FAIL mul_result got=%h exp=%h", res, -64'sd21); end
        n_cmp++; if (lat !== 64) begin n_bad++; $display("FAIL mul_latency got=%0d exp=64", lat); end
        n_cmp++; if (st !== 64) begin n_bad++; $display("FAIL mul_stall_cycles got=%0d exp=64", st); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            n_cmp++; if (done_o !== 1'b1 || result_o !== -64'sd21 || stall_o !== 1'b0) begin
                n_bad++; $display("FAIL mul_hold done=%b stall=%b got=%h exp=%h", done_o, stall_o, result_o, -64'sd21);
            end
        end
        retire();
        #1;
        n_cmp++; if (done_o !== 1'b0) begin n_bad++; $display("FAIL mul_advance done=%b exp=0", done_o); end
    endtask

    task automatic test_mulw();
        logic [63:0] res; int lat, st;
        run_op(ALU_MUL, 1'b0, 1'b1, 64'h0000_0000_8000_0000, 64'd2, 1'b0, res, lat, st);
        n_cmp++; if (res !== 64'h0) begin n_bad++; $display("FAIL mulw_result got=%h exp=0", res); end
        n_cmp++; if (lat !== 32) begin n_bad++; $display("FAIL mulw_latency got=%0d exp=32", lat); end
        retire();
    endtask

    task automatic test_div_directed();
        logic [63:0] res; int lat, st;
        run_op(ALU_DIV, 1'b1, 1'b0, -64'sd7, 64'd2, 1'b0, res, lat, st);
        n_cmp++; if (res !== -64'sd3) begin n_bad++; $display("FAIL div_signed got=%h exp=%h", res, -64'sd3); end
        retire();
        run_op(ALU_REM, 1'b1, 1'b0, -64'sd7, 64'd2, 1'b0, res, lat, st);
        n_cmp++; if (res !== -64'sd1) begin n_bad++; $display("FAIL rem_signed got=%h exp=%h", res, -64'sd1); end
        retire();
        run_op(ALU_DIV, 1'b0, 1'b0, 64'd100, 64'd7, 1'b0, res, lat, st);
        n_cmp++; if (res !== 64'd14) begin n_bad++; $display("FAIL divu_result got=%h exp=14", res); end
        n_cmp++; if (lat !== 64) begin n_bad++; $display("FAIL divu_latency got=%0d exp=64", lat); end
        retire();
    endtask

    task automatic test_div_special();
        logic [63:0] res; int lat, st;
        run_op(ALU_DIV, 1'b1, 1'b0, 64'd5, 64'd0, 1'b0, res, lat, st);
        n_cmp++; if (res !== 64'hFFFF_FFFF_FFFF_FFFF) begin n_bad++; $display("FAIL div0_result got=%h exp=all-ones", res); end
        n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL div0_latency got=%0d exp=1", lat); end
        retire();
        run_op(ALU_REM, 1'b1, 1'b0, 64'd5, 64'd0, 1'b0, res, lat, st);
        n_cmp++; if (res !== 64'd5) begin n_bad++; $display("FAIL rem0_result got=%h exp=5", res); end
        retire();
        run_op(ALU_DIV, 1'b1, 1'b1, 64'h0000_0000_8000_0000, -64'sd1, 1'b0, res, lat, st);
        n_cmp++; if (res !== 64'hFFFF_FFFF_8000_0000) begin n_bad++; $display("FAIL divw_ovf got=%h exp=ffffffff80000000", res); end
        n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL divw_ovf_latency got=%0d exp=1", lat); end
        retire();
    endtask

    task automatic test_flush();
        logic [63:0] res, prev; int lat, st, seen;
        prev = result_o;
        @(negedge clk);
        valid_i = 1'b1; func_i = ALU_DIV; sign_i = 1'b0; cut_i = 1'b0; a_i = 64'd1000; b_i = 64'd3;
        repeat (10) @(negedge clk);
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0; valid_i = 1'b0;
        #1;
        n_cmp++; if (done_o !== 1'b0 || stall_o !== 1'b0) begin n_bad++; $display("FAIL flush_idle done=%b stall=%b exp=0/0", done_o, stall_o); end
        n_cmp++; if (result_o !== prev) begin n_bad++; $display("FAIL flush_keep got=%h exp=%h", result_o, prev); end
        seen = 0;
        for (int i = 0; i < 80; i++) begin @(negedge clk); if (done_o === 1'b1) seen++; end
        n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL flush_no_done got=%0d exp=0", seen); end
        // claim and flush together in IDLE: nothing starts
        valid_i = 1'b1; func_i = ALU_MUL; a_i = 64'd9; b_i = 64'd9; flush_i = 1'b1;
        @(negedge clk);
        valid_i = 1'b0; flush_i = 1'b0;
        seen = 0;
        for (int i = 0; i < 70; i++) begin @(negedge clk); if (done_o === 1'b1) seen++; end
        n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL flush_claim_no_done got=%0d exp=0", seen); end
        run_op(ALU_MUL, 1'b0, 1'b0, 64'd3, 64'd4, 1'b0, res, lat, st);
        n_cmp++; if (res !== 64'd12) begin n_bad++; $display("FAIL mul_after_flush got=%h exp=12", res); end
        // flush beats advance in DONE; result is kept
        flush_i = 1'b1; advance_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0; advance_i = 1'b0; valid_i = 1'b0;
        #1;
        n_cmp++; if (done_o !== 1'b0 || result_o !== 64'd12) begin n_bad++; $display("FAIL flush_advance done=%b got=%h exp=0/12", done_o, result_o); end
    endtask

    task automatic test_back_to_back();
        logic [63:0] res; int lat, st;
        run_op(ALU_MUL, 1'b0, 1'b0, 64'd6, 64'd7, 1'b0, res, lat, st);
        n_cmp++; if (res !== 64'd42) begin n_bad++; $display("FAIL b2b_mul got=%h exp=42", res); end
        advance_i = 1'b1;
        @(negedge clk);
        run_op(ALU_DIV, 1'b0, 1'b0, 64'd42, 64'd6, 1'b1, res, lat, st);
        n_cmp++; if (res !== 64'd7 || lat !== 64) begin n_bad++; $display("FAIL b2b_div got=%h lat=%0d exp=7/64", res, lat); end
        retire();
        valid_i = 1'b1; func_i = ALU_ADD;
        repeat (3) @(negedge clk);
        #1;
        n_cmp++; if (stall_o !== 1'b0 || done_o !== 1'b0) begin n_bad++; $display("FAIL non_md stall=%b done=%b exp=0/0", stall_o, done_o); end
        valid_i = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [63:0] res; int lat, st;
        @(negedge clk);
        valid_i = 1'b1; func_i = ALU_MUL; sign_i = 1'b0; cut_i = 1'b0; a_i = 64'd11; b_i = 64'd13;
        repeat (20) @(negedge clk);
        #2 resetn = 1'b0;
        #1;
        n_cmp++; if (stall_o !== 1'b0 || done_o !== 1'b0 || result_o !== 64'h0) begin
            n_bad++; $display("FAIL reset_mid stall=%b done=%b got=%h exp=0/0/0", stall_o, done_o, result_o);
        end
        valid_i = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        run_op(ALU_DIV, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, res, lat, st);
        n_cmp++; if (res !== 64'hFFFF_FFFF_FFFF_FFFF) begin n_bad++; $display("FAIL divuw_result got=%h exp=all-ones", res); end
        n_cmp++; if (lat !== 32) begin n_bad++; $display("FAIL divuw_latency got=%0d exp=32", lat); end
        retire();
    endtask

    task automatic test_random();
        logic [63:0] res, a, b, exp; logic [4:0] f; logic s, c; int lat, st, exp_lat, sel;
        for (int i = 0; i < 40; i++) begin
            sel = $urandom_range(0, 2);
            f = (sel == 0) ? ALU_MUL : (sel == 1) ? ALU_DIV : ALU_REM;
            s = 1'($urandom_range(0, 1));
            c = 1'($urandom_range(0, 1));
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            sel = $urandom_range(0, 7);
            if (sel == 0) b = c ? {b[63:32], 32'h0} : 64'h0;
            else if (sel == 1) begin
                a = c ? {a[63:32], 32'h8000_0000} : {1'b1, 63'h0};
                b = '1;
            end else if (sel == 2) b = {56'h0, b[7:0]};
            exp     = ref_result(f, s, c, a, b);
            exp_lat = ref_latency(f, s, c, a, b);
            run_op(f, s, c, a, b, 1'b0, res, lat, st);
            n_cmp++; if (res !== exp || lat !== exp_lat) begin
                n_bad++;
                $display("FAIL random[%0d] f=%0d s=%b c=%b a=%h b=%h got=%h lat=%0d exp=%h lat=%0d",
                         i, f, s, c, a, b, res, lat, exp, exp_lat);
            end
            retire();
        end
    endtask

    initial begin
        test_reset();
        test_mul_basic();
        test_mulw();
        test_div_directed();
        test_div_special();
        test_flush();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
